// File: rtl/dmx_frame_buffer.sv
// Double-buffered DMX slot store: host fills the back bank, the transmitter reads the front bank,
// banks swap on a frame boundary after a commit, then a copy engine resyncs the new back bank.
module dmx_frame_buffer #(
  parameter int NUM_SLOTS = 512,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 8
) (
  input  logic              dmxclk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              commit,
  output logic              commit_pending,
  input  logic              frame_start,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              active_bank,
  output logic [15:0]       frame_count
);

  localparam int IDX_W = $clog2(NUM_SLOTS);
  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] SLOTS    = PTR_W'(NUM_SLOTS);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_COPY} state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   ptr_reg;
  logic               active_bank_reg;
  logic               commit_pending_reg;
  logic               copy_pend_reg;
  logic [IDX_W-1:0]   copy_idx_reg;
  logic               rd_valid_reg;
  logic               rd_zero_reg;
  logic               rd_bank_reg;
  logic [15:0]        frame_count_reg;

  logic               swap, copy_issue, host_we, copy_we;
  logic [1:0]         bank_we;
  logic [IDX_W-1:0]   widx, ridx;
  logic [DATA_W-1:0]  wdata, ram_q;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < SLOTS;
  endfunction

  always_comb begin
    state_next = state_reg;
    swap       = 1'b0;
    copy_issue = 1'b0;
    host_we    = 1'b0;
    copy_we    = 1'b0;
    case (state_reg)
      S_INIT: if (ptr_reg == LAST_PTR) state_next = S_IDLE;
      S_IDLE: begin
        host_we = wr_en & in_range(wr_addr);
        if (frame_start && commit_pending_reg) begin
          swap       = 1'b1;
          state_next = S_COPY;
        end
      end
      S_COPY: begin
        // The transmitter owns the front-bank port whenever it asks for it.
        copy_issue = ~rd_req & (ptr_reg < SLOTS);
        copy_we    = copy_pend_reg;
        if (copy_pend_reg && copy_idx_reg == LAST_IDX) state_next = S_IDLE;
      end
      default: state_next = S_INIT;
    endcase
  end

  always_comb begin
    widx  = wr_addr[IDX_W-1:0];
    wdata = wr_data;
    if (state_reg == S_INIT) begin
      widx  = ptr_reg[IDX_W-1:0];
      wdata = '0;
    end else if (state_reg == S_COPY) begin
      widx  = copy_idx_reg;
      wdata = ram_q;
    end
    ridx = rd_req ? rd_addr[IDX_W-1:0] : ptr_reg[IDX_W-1:0];
    for (int b = 0; b < 2; b++) begin
      bank_we[b] = (state_reg == S_INIT) |
                   ((host_we | copy_we) & (active_bank_reg != 1'(b)));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      logic [DATA_W-1:0] mem [NUM_SLOTS];
      logic [DATA_W-1:0] q_reg;
      always_ff @(posedge dmxclk) begin
        if (bank_we[gi]) mem[widx] <= wdata;
        q_reg <= mem[ridx];
      end
    end
  endgenerate

  assign ram_q = rd_bank_reg ? g_bank[1].q_reg : g_bank[0].q_reg;

  always_ff @(posedge dmxclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= S_INIT;
      ptr_reg            <= '0;
      active_bank_reg    <= 1'b0;
      commit_pending_reg <= 1'b0;
      copy_pend_reg      <= 1'b0;
      copy_idx_reg       <= '0;
      rd_valid_reg       <= 1'b0;
      rd_zero_reg        <= 1'b1;
      rd_bank_reg        <= 1'b0;
      frame_count_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      copy_pend_reg <= copy_issue;
      copy_idx_reg  <= ptr_reg[IDX_W-1:0];
      rd_valid_reg  <= rd_req;
      rd_zero_reg   <= (state_reg == S_INIT) | ~in_range(rd_addr);
      rd_bank_reg   <= active_bank_reg;
      if (frame_start) frame_count_reg <= frame_count_reg + 16'd1;
      case (state_reg)
        S_INIT: ptr_reg <= ptr_reg + 1'b1;
        S_IDLE: if (swap) ptr_reg <= '0;
        S_COPY: if (copy_issue) ptr_reg <= ptr_reg + 1'b1;
        default: ptr_reg <= '0;
      endcase
      if (swap) begin
        active_bank_reg    <= ~active_bank_reg;
        commit_pending_reg <= 1'b0;
      end else if (state_reg == S_IDLE && commit) begin
        commit_pending_reg <= 1'b1;
      end
    end
  end

  assign wr_ready       = (state_reg == S_IDLE);
  assign commit_pending = commit_pending_reg;
  assign active_bank    = active_bank_reg;
  assign frame_count    = frame_count_reg;
  assign rd_valid       = rd_valid_reg;
  assign rd_data        = (rd_valid_reg && !rd_zero_reg) ? ram_q : '0;

endmodule

// File: tb/tb_dmx_frame_buffer.sv
// Scoreboard bench for dmx_frame_buffer: reads push expected data, a monitor pops on rd_valid.
module tb_dmx_frame_buffer;
  localparam int AW = 10;

  logic          dmxclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0, commit = 1'b0, frame_start = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [7:0]    wr_data = '0, rd_exp = '0;
  logic          wr_ready, commit_pending, rd_valid, active_bank;
  logic [7:0]    rd_data;
  logic [15:0]   frame_count;

  typedef struct {logic [AW-1:0] addr; logic [7:0] data;} rd_t;
  rd_t  exp_q[$];
  int   passed = 0, total = 0, fs_cnt = 0;
  bit   req_q = 1'b0;

  dmx_frame_buffer #(.NUM_SLOTS(512), .ADDR_W(AW), .DATA_W(8)) dut (
    .dmxclk(dmxclk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .commit(commit), .commit_pending(commit_pending),
    .frame_start(frame_start), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .active_bank(active_bank), .frame_count(frame_count)
  );

  always #5 dmxclk = ~dmxclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge dmxclk) begin
    req_q = rd_req && rst_n;
    if (rd_req && rst_n) exp_q.push_back('{rd_addr, rd_exp});
    if (frame_start && rst_n) fs_cnt++;
  end

  always @(negedge dmxclk) begin
    if (rst_n && (req_q || rd_valid)) begin
      chk("rd_valid", rd_valid, req_q);
      if (rd_valid) begin
        if (exp_q.size() == 0) chk("rd_queue_nonempty", exp_q.size(), 1);
        else begin
          rd_t e;
          e = exp_q.pop_front();
          $display("read addr=%0d data=%02h expected=%02h", e.addr, rd_data, e.data);
          chk("rd_data", rd_data, e.data);
        end
      end
    end
  end

  task automatic step();
    @(negedge dmxclk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!wr_ready && n < 5000) begin
      step();
      n++;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [7:0] e);
    rd_req = 1'b1; rd_addr = a; rd_exp = e;
    step();
    rd_req = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    int n;
    int rem;
    logic [7:0] tab [3];
    tab[0] = 8'hAA; tab[1] = 8'h55; tab[2] = 8'h77;

    repeat (3) step();
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_active_bank", active_bank, 0);
    chk("rst_commit_pending", commit_pending, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_frame_count", frame_count, 0);

    rst_n = 1'b1;
    rd_req = 1'b1; rd_addr = 10'h1FF; rd_exp = 8'h00;
    wait_ready(n);
    rd_req = 1'b0;
    chk("init_cycles", n, 512);
    chk("init_frame_count", frame_count, 0);
    step();

    wr(10'd5, 8'hAA);
    pulse_commit();
    chk("commit_pending_set", commit_pending, 1);
    chk("no_swap_yet", active_bank, 0);
    pulse_frame();
    chk("swap1_active", active_bank, 1);
    chk("swap1_pending_clr", commit_pending, 0);
    rd(10'd5, 8'hAA);
    wait_ready(n);
    chk("copy_cycles_one_stall", n, 513);

    wr(10'd6, 8'h55);
    pulse_commit();
    pulse_frame();
    chk("swap2_active", active_bank, 0);
    wait_ready(n);
    chk("copy_cycles_plain", n, 513);
    rd(10'd5, 8'hAA);
    rd(10'd6, 8'h55);
    rd(10'd7, 8'h00);

    wr_en = 1'b1; wr_addr = 10'd7; wr_data = 8'h77; commit = 1'b1; frame_start = 1'b1;
    step();
    wr_en = 1'b0; commit = 1'b0; frame_start = 1'b0;
    chk("commit_with_frame_no_swap", active_bank, 0);
    chk("commit_with_frame_pending", commit_pending, 1);
    pulse_frame();
    chk("swap3_active", active_bank, 1);

    for (int i = 0; i < 512; i++) begin
      if (i % 2 == 0) begin
        rd_req = 1'b1; rd_addr = AW'(5 + (i / 2) % 3); rd_exp = tab[(i / 2) % 3];
      end else begin
        rd_req = 1'b0;
      end
      step();
    end
    rd_req = 1'b0;
    wait_ready(n);
    chk("copy_cycles_alt_reads", n, 257);
    rd(10'd7, 8'h77);
    rd(10'd8, 8'h00);

    pulse_frame();
    chk("frame_no_pending_no_swap", active_bank, 1);

    wr(10'd600, 8'h12);
    rd(10'd600, 8'h00);
    pulse_commit();
    pulse_frame();
    chk("swap4_active", active_bank, 0);
    rd(10'd88, 8'h00);
    rd(10'd7, 8'h77);
    wait_ready(n);
    chk("copy4_done", wr_ready, 1);

    chk("frame_count_track", frame_count, fs_cnt[15:0]);
    rem = 65536 - fs_cnt;
    frame_start = 1'b1;
    repeat (rem - 1) step();
    chk("frame_count_max", frame_count, 16'hFFFF);
    step();
    frame_start = 1'b0;
    chk("frame_count_wrap", frame_count, 0);

    wr(10'd9, 8'h33);
    pulse_commit();
    pulse_frame();
    repeat (20) step();
    rst_n = 1'b0;
    #1;
    chk("midcopy_rst_wr_ready", wr_ready, 0);
    chk("midcopy_rst_active", active_bank, 0);
    chk("midcopy_rst_frame_count", frame_count, 0);
    step();
    rst_n = 1'b1;
    wait_ready(n);
    chk("reinit_cycles", n, 512);
    rd(10'd9, 8'h00);
    rd(10'd5, 8'h00);
    step();
    step();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
